// File: rtl/mips_core_pkg.sv
// Shared core definitions: datapath widths and write-back requester indices.
package mips_core_pkg;

    localparam int PHYS_REG_NUM_INDEX = 6;
    localparam int DATA_WIDTH = 32;
    localparam int ACTIVE_LIST_SIZE_INDEX = 5;

    localparam int WB_NUM_REQ = 3;

    typedef enum logic [1:0] {
        WB_REQ_ALU = 2'd0,
        WB_REQ_MEM = 2'd1,
        WB_REQ_MUL = 2'd2
    } wb_req_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_priority_picker #(
    parameter int N = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          grant_valid
);

    int idx;

    always_comb begin
        grant = '0;
        grant_valid = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant[idx] = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant among result producers, one registered
// write-back/commit per cycle.
module wb_arbiter
    import mips_core_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_uses_rw,
    input  logic [NUM_REQ-1:0][PHYS_REG_NUM_INDEX-1:0] req_rw_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rw_data,
    input  logic [NUM_REQ-1:0][ACTIVE_LIST_SIZE_INDEX-1:0] req_al_id,
    input  logic flush,
    output logic wb_valid,
    output logic wb_uses_rw,
    output logic [PHYS_REG_NUM_INDEX-1:0] wb_rw_addr,
    output logic [DATA_WIDTH-1:0] wb_rw_data,
    output logic commit_valid,
    output logic [ACTIVE_LIST_SIZE_INDEX-1:0] commit_al_id
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic grant_valid;
    logic xfer;
    logic [PW-1:0] win;
    logic [PW-1:0] next_ptr;

    rr_priority_picker #(
        .N(NUM_REQ),
        .PW(PW)
    ) u_picker (
        .req(req_valid),
        .ptr(rr_ptr),
        .grant(grant),
        .grant_valid(grant_valid)
    );

    // Flush and reset both veto the grant before it reaches the requesters.
    assign req_ready = (flush || !rst_n) ? '0 : grant;
    assign xfer = grant_valid && !flush && rst_n;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win = PW'(i);
            end
        end
    end

    assign next_ptr = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wb_valid <= 1'b0;
            commit_valid <= 1'b0;
            wb_uses_rw <= 1'b0;
            wb_rw_addr <= '0;
            wb_rw_data <= '0;
            commit_al_id <= '0;
        end else begin
            wb_valid <= xfer;
            commit_valid <= xfer;
            if (xfer) begin
                rr_ptr <= next_ptr;
                wb_uses_rw <= req_uses_rw[win];
                wb_rw_addr <= req_rw_addr[win];
                wb_rw_data <= req_rw_data[win];
                commit_al_id <= req_al_id[win];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed checks of wb_arbiter: reset, fairness, wrap, flush, store, reset mid-traffic.
module tb_wb_arbiter;
    import mips_core_pkg::*;

    localparam int N = WB_NUM_REQ;

    logic clk;
    logic rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_uses_rw;
    logic [N-1:0][PHYS_REG_NUM_INDEX-1:0] req_rw_addr;
    logic [N-1:0][DATA_WIDTH-1:0] req_rw_data;
    logic [N-1:0][ACTIVE_LIST_SIZE_INDEX-1:0] req_al_id;
    logic flush;
    logic wb_valid;
    logic wb_uses_rw;
    logic [PHYS_REG_NUM_INDEX-1:0] wb_rw_addr;
    logic [DATA_WIDTH-1:0] wb_rw_data;
    logic commit_valid;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] commit_al_id;

    int total = 0;
    int bad = 0;

    wb_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_uses_rw(req_uses_rw),
        .req_rw_addr(req_rw_addr),
        .req_rw_data(req_rw_data),
        .req_al_id(req_al_id),
        .flush(flush),
        .wb_valid(wb_valid),
        .wb_uses_rw(wb_uses_rw),
        .wb_rw_addr(wb_rw_addr),
        .wb_rw_data(wb_rw_data),
        .commit_valid(commit_valid),
        .commit_al_id(commit_al_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            req_uses_rw[i] = 1'b1;
            req_rw_addr[i] = PHYS_REG_NUM_INDEX'(i + 1);
            req_rw_data[i] = DATA_WIDTH'(32'hA0 + i);
            req_al_id[i] = ACTIVE_LIST_SIZE_INDEX'(10 + i);
        end
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_commit_valid", 32'(commit_valid), 32'h0);
        chk("rst_ptr", 32'(dut.rr_ptr), 32'h0);
        chk("rst_data", wb_rw_data, 32'h0);
        chk("rst_al_id", 32'(commit_al_id), 32'h0);
        chk("rst_addr", 32'(wb_rw_addr), 32'h0);

        // Release reset; six back-to-back grants 0,1,2,0,1,2.
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("fair_ready", 32'(req_ready), 32'(1 << (c % 3)));
            tick();
            chk("fair_wb_valid", 32'(wb_valid), 32'h1);
            chk("fair_commit_valid", 32'(commit_valid), 32'h1);
            chk("fair_data", wb_rw_data, 32'hA0 + (c % 3));
            chk("fair_addr", 32'(wb_rw_addr), 32'(1 + c % 3));
            chk("fair_al_id", 32'(commit_al_id), 32'(10 + c % 3));
            chk("fair_ptr", 32'(dut.rr_ptr), 32'((c + 1) % 3));
        end

        // Idle cycle: nothing granted, pointer holds.
        req_valid = 3'b000;
        #1;
        chk("idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("idle_wb_valid", 32'(wb_valid), 32'h0);
        chk("idle_ptr", 32'(dut.rr_ptr), 32'h0);

        // Move pointer to 2 via requester 1.
        req_valid = 3'b010;
        #1;
        chk("pre_wrap_ready", 32'(req_ready), 32'h2);
        tick();
        chk("pre_wrap_ptr", 32'(dut.rr_ptr), 32'h2);

        // Wrap: 2, 0, 2 with pointer 0, 1, 0.
        req_valid = 3'b101;
        #1;
        chk("wrap0_ready", 32'(req_ready), 32'h4);
        tick();
        chk("wrap0_ptr", 32'(dut.rr_ptr), 32'h0);
        chk("wrap0_data", wb_rw_data, 32'hA2);
        chk("wrap1_ready", 32'(req_ready), 32'h1);
        tick();
        chk("wrap1_ptr", 32'(dut.rr_ptr), 32'h1);
        chk("wrap1_data", wb_rw_data, 32'hA0);
        chk("wrap2_ready", 32'(req_ready), 32'h4);
        tick();
        chk("wrap2_ptr", 32'(dut.rr_ptr), 32'h0);
        chk("wrap2_data", wb_rw_data, 32'hA2);

        // Flush blocks grant; held request goes through next cycle.
        req_valid = 3'b010;
        req_rw_data[1] = 32'hDEAD_BEEF;
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'h0);
        tick();
        chk("flush_wb_valid", 32'(wb_valid), 32'h0);
        chk("flush_commit_valid", 32'(commit_valid), 32'h0);
        chk("flush_ptr", 32'(dut.rr_ptr), 32'h0);
        flush = 1'b0;
        #1;
        chk("post_flush_ready", 32'(req_ready), 32'h2);
        tick();
        chk("post_flush_wb_valid", 32'(wb_valid), 32'h1);
        chk("post_flush_data", wb_rw_data, 32'hDEAD_BEEF);
        chk("post_flush_ptr", 32'(dut.rr_ptr), 32'h2);

        // Store from MEM: commits without a register write.
        req_uses_rw[WB_REQ_MEM] = 1'b0;
        req_al_id[WB_REQ_MEM] = 5'd5;
        #1;
        chk("store_ready", 32'(req_ready), 32'h2);
        tick();
        chk("store_wb_valid", 32'(wb_valid), 32'h1);
        chk("store_uses_rw", 32'(wb_uses_rw), 32'h0);
        chk("store_commit_valid", 32'(commit_valid), 32'h1);
        chk("store_al_id", 32'(commit_al_id), 32'h5);

        // Reset the cycle after a transfer.
        req_uses_rw[WB_REQ_MEM] = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("rt_ready", 32'(req_ready), 32'h4);
        tick();
        chk("rt_wb_valid", 32'(wb_valid), 32'h1);
        chk("rt_uses_rw", 32'(wb_uses_rw), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rt_drop_wb_valid", 32'(wb_valid), 32'h0);
        chk("rt_drop_commit", 32'(commit_valid), 32'h0);
        chk("rt_drop_ready", 32'(req_ready), 32'h0);
        chk("rt_drop_data", wb_rw_data, 32'h0);
        tick();
        req_valid = 3'b000;
        rst_n = 1'b1;
        tick();
        chk("rt_after_wb_valid", 32'(wb_valid), 32'h0);
        chk("rt_after_ptr", 32'(dut.rr_ptr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
